// File: rtl/instr_prefetch_pkg.sv
// Shared defaults and FSM encoding for the instruction prefetch unit.
package instr_prefetch_pkg;

    localparam int PC_WIDTH_DEF    = 10;
    localparam int INSTR_WIDTH_DEF = 16;
    localparam int RESET_PC_DEF    = 0;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs; flush empties it in one cycle.
module prefetch_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// Fetch PC, run/halt FSM and push/pop arbitration in front of IF/ID.
// Optional PREFETCH_BYPASS_EN: forward the ROM word directly when the queue is empty.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int DEPTH       = 4,
    parameter int RESET_PC    = RESET_PC_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic [PC_WIDTH-1:0]      rom_addr,
    input  logic [INSTR_WIDTH-1:0]   rom_data,
    input  logic                     redirect,
    input  logic [PC_WIDTH-1:0]      redirect_pc,
    input  logic                     halt_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     halted
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = PC_WIDTH + INSTR_WIDTH;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [DW-1:0]       rdata;
    logic                q_valid;
    logic                q_full;
    logic                q_pop;
    logic                run_ok;
    logic                fetch;
    logic                fifo_push;

    assign q_valid = (count != '0);
    assign q_full  = (count == CW'(DEPTH));
    assign q_pop   = q_valid & out_ready;
    assign run_ok  = (state == ST_RUN) & ~redirect & ~halt_req;
    // A pop in the same cycle frees the slot, so a full queue can still fetch.
    assign fetch   = run_ok & (~q_full | q_pop);

    always_comb begin
        fifo_push = fetch;
        out_valid = q_valid;
        out_pc    = q_valid ? rdata[DW-1 -: PC_WIDTH] : '0;
        out_instr = q_valid ? rdata[INSTR_WIDTH-1:0] : '0;
`ifdef PREFETCH_BYPASS_EN
        if (run_ok && !q_valid) begin
            out_valid = 1'b1;
            out_pc    = pc;
            out_instr = rom_data;
            fifo_push = fetch & ~out_ready;
        end
`endif
    end

    prefetch_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .pop   (q_pop),
        .flush (redirect),
        .wdata ({pc, rom_data}),
        .rdata (rdata),
        .count (count)
    );

    // Redirect outranks everything, including leaving HALTED.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc    <= PC_WIDTH'(RESET_PC);
            state <= ST_RUN;
        end else if (redirect) begin
            pc    <= redirect_pc;
            state <= ST_RUN;
        end else begin
            if (fetch) begin
                pc <= pc + PC_WIDTH'(1);
            end
            if (state == ST_RUN && halt_req) begin
                state <= ST_HALTED;
            end
        end
    end

    assign rom_addr = pc;
    assign halted   = (state == ST_HALTED);

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed table-driven bench for instr_prefetch; ROM word is 16'h1000 + address.
module tb_instr_prefetch;

    logic        clk;
    logic        rstn;
    logic [9:0]  rom_addr;
    logic [15:0] rom_data;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [9:0]  out_pc;
    logic [2:0]  count;
    logic        halted;

    int n_vec;
    int n_fail;

    typedef struct {
        logic        redirect;
        logic [9:0]  redirect_pc;
        logic        halt_req;
        logic        out_ready;
        logic        exp_valid;
        logic [9:0]  exp_pc;
        logic [15:0] exp_instr;
        logic [2:0]  exp_count;
        logic        exp_halted;
        logic [9:0]  exp_addr;
    } vec_t;

    vec_t vecs[$];

    instr_prefetch dut (
        .clk         (clk),
        .rstn        (rstn),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt_req    (halt_req),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .count       (count),
        .halted      (halted)
    );

    assign rom_data = 16'h1000 + {6'b0, rom_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [9:0] rpc, input logic h,
                                input logic rdy, input logic ev, input logic [9:0] epc,
                                input logic [15:0] ei, input logic [2:0] ec,
                                input logic eh, input logic [9:0] ea);
        vec_t v;
        v.redirect = r;  v.redirect_pc = rpc; v.halt_req = h; v.out_ready = rdy;
        v.exp_valid = ev; v.exp_pc = epc; v.exp_instr = ei; v.exp_count = ec;
        v.exp_halted = eh; v.exp_addr = ea;
        return v;
    endfunction

    task automatic apply_stimulus(input logic r, input logic [9:0] rpc,
                                  input logic h, input logic rdy);
        redirect    = r;
        redirect_pc = rpc;
        halt_req    = h;
        out_ready   = rdy;
    endtask

    task automatic check_output(input string name, input logic ev, input logic [9:0] epc,
                                input logic [15:0] ei, input logic [2:0] ec,
                                input logic eh, input logic [9:0] ea);
        n_vec++;
        if (out_valid !== ev || out_pc !== epc || out_instr !== ei ||
            count !== ec || halted !== eh || rom_addr !== ea) begin
            n_fail++;
            $display("[TB] FAIL %s: got valid=%b pc=%h instr=%h count=%0d halted=%b addr=%h, want valid=%b pc=%h instr=%h count=%0d halted=%b addr=%h",
                     name, out_valid, out_pc, out_instr, count, halted, rom_addr,
                     ev, epc, ei, ec, eh, ea);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rstn   = 1'b0;
        apply_stimulus(1'b0, 10'h000, 1'b0, 1'b0);

`ifndef PREFETCH_BYPASS_EN
        // fill, full-stream, halt/drain, redirect flush, redirect+halt, pc wrap
        vecs.push_back(mk(0, 10'h000, 0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000));
        vecs.push_back(mk(0, 10'h000, 0, 0, 1, 10'h000, 16'h1000, 1, 0, 10'h001));
        vecs.push_back(mk(0, 10'h000, 0, 0, 1, 10'h000, 16'h1000, 2, 0, 10'h002));
        vecs.push_back(mk(0, 10'h000, 0, 0, 1, 10'h000, 16'h1000, 3, 0, 10'h003));
        vecs.push_back(mk(0, 10'h000, 0, 0, 1, 10'h000, 16'h1000, 4, 0, 10'h004));
        vecs.push_back(mk(0, 10'h000, 0, 1, 1, 10'h000, 16'h1000, 4, 0, 10'h004));
        vecs.push_back(mk(0, 10'h000, 0, 1, 1, 10'h001, 16'h1001, 4, 0, 10'h005));
        vecs.push_back(mk(0, 10'h000, 1, 1, 1, 10'h002, 16'h1002, 4, 0, 10'h006));
        vecs.push_back(mk(0, 10'h000, 0, 1, 1, 10'h003, 16'h1003, 3, 1, 10'h006));
        vecs.push_back(mk(0, 10'h000, 0, 1, 1, 10'h004, 16'h1004, 2, 1, 10'h006));
        vecs.push_back(mk(0, 10'h000, 0, 1, 1, 10'h005, 16'h1005, 1, 1, 10'h006));
        vecs.push_back(mk(0, 10'h000, 0, 1, 0, 10'h000, 16'h0000, 0, 1, 10'h006));
        vecs.push_back(mk(0, 10'h000, 1, 1, 0, 10'h000, 16'h0000, 0, 1, 10'h006));
        vecs.push_back(mk(1, 10'h000, 0, 1, 0, 10'h000, 16'h0000, 0, 1, 10'h006));
        vecs.push_back(mk(0, 10'h000, 0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000));
        vecs.push_back(mk(0, 10'h000, 0, 0, 1, 10'h000, 16'h1000, 1, 0, 10'h001));
        vecs.push_back(mk(0, 10'h000, 0, 0, 1, 10'h000, 16'h1000, 2, 0, 10'h002));
        vecs.push_back(mk(1, 10'h155, 0, 1, 1, 10'h000, 16'h1000, 3, 0, 10'h003));
        vecs.push_back(mk(0, 10'h000, 0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h155));
        vecs.push_back(mk(1, 10'h3FE, 1, 0, 1, 10'h155, 16'h1155, 1, 0, 10'h156));
        vecs.push_back(mk(0, 10'h000, 0, 1, 0, 10'h000, 16'h0000, 0, 0, 10'h3FE));
        vecs.push_back(mk(0, 10'h000, 0, 1, 1, 10'h3FE, 16'h13FE, 1, 0, 10'h3FF));
        vecs.push_back(mk(0, 10'h000, 0, 1, 1, 10'h3FF, 16'h13FF, 1, 0, 10'h000));
        vecs.push_back(mk(0, 10'h000, 0, 0, 1, 10'h000, 16'h1000, 1, 0, 10'h001));
        vecs.push_back(mk(0, 10'h000, 0, 0, 1, 10'h000, 16'h1000, 2, 0, 10'h002));

        repeat (2) @(negedge clk);
        #1 check_output("in_reset", 0, 10'h000, 16'h0000, 0, 0, 10'h000);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            apply_stimulus(vecs[i].redirect, vecs[i].redirect_pc,
                           vecs[i].halt_req, vecs[i].out_ready);
            #1 check_output($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                            vecs[i].exp_instr, vecs[i].exp_count, vecs[i].exp_halted,
                            vecs[i].exp_addr);
        end

        // Asynchronous reset mid-stream with two entries queued.
        #2 rstn = 1'b0;
        #1 check_output("async_reset", 0, 10'h000, 16'h0000, 0, 0, 10'h000);
        #3 check_output("reset_hold", 0, 10'h000, 16'h0000, 0, 0, 10'h000);
        @(negedge clk);
        rstn = 1'b1;
        apply_stimulus(1'b0, 10'h000, 1'b0, 1'b1);
        #1 check_output("post_rst_c0", 0, 10'h000, 16'h0000, 0, 0, 10'h000);
        @(negedge clk);
        #1 check_output("post_rst_c1", 1, 10'h000, 16'h1000, 1, 0, 10'h001);
        @(negedge clk);
        #1 check_output("post_rst_c2", 1, 10'h001, 16'h1001, 1, 0, 10'h002);
`else
        repeat (2) @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        apply_stimulus(1'b0, 10'h000, 1'b0, 1'b1);
        #1 check_output("byp_c0", 1, 10'h000, 16'h1000, 0, 0, 10'h000);
        @(negedge clk);
        #1 check_output("byp_c1", 1, 10'h001, 16'h1001, 0, 0, 10'h001);
        apply_stimulus(1'b0, 10'h000, 1'b0, 1'b0);
        #1 check_output("byp_hold", 1, 10'h001, 16'h1001, 0, 0, 10'h001);
        @(negedge clk);
        #1 check_output("byp_queued", 1, 10'h001, 16'h1001, 1, 0, 10'h002);
        apply_stimulus(1'b0, 10'h000, 1'b1, 1'b1);
        #1 check_output("byp_halt", 1, 10'h001, 16'h1001, 1, 0, 10'h002);
        @(negedge clk);
        #1 check_output("byp_halted", 0, 10'h000, 16'h0000, 0, 1, 10'h002);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
